// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle for the FIFO stream reader: FIFO pop side plus valid/ready output side.
// The master modport is the reader; the slave modport is the FIFO and downstream sink together.
interface fifo_stream_reader_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty_i;
    logic [DATA_W-1:0] fifo_data_i;
    logic              pop_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;

    modport master (
        input  fifo_empty_i,
        input  fifo_data_i,
        input  out_ready_i,
        output pop_o,
        output out_valid_o,
        output out_data_o
    );

    modport slave (
        output fifo_empty_i,
        output fifo_data_i,
        output out_ready_i,
        input  pop_o,
        input  out_valid_o,
        input  out_data_o
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a push/pop FIFO into a registered valid/ready stream through a 2-entry output/skid buffer.
//
// state   | meaning
// S_EMPTY | no words held, out_valid_o low
// S_ONE   | output register holds a word
// S_TWO   | output and skid registers both hold words; skid is the younger word
module fifo_stream_reader #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_stream_reader_if.master bus,
    input  logic                 flush_i,
    output logic                 idle_o,
    output logic [CNT_W-1:0]     count_o
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_out_data;
    logic [DATA_W-1:0] w_out_data_nxt;
    logic [DATA_W-1:0] r_skid_data;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_out_valid;
    logic              w_pop;
    logic              w_acc;

    // Pop only looks at registered occupancy, so the FIFO never sees a path from out_ready_i.
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_pop       = !bus.fifo_empty_i && (r_state != S_TWO) && !flush_i && !reset;
    assign w_acc       = w_out_valid && bus.out_ready_i;

    assign bus.pop_o       = w_pop;
    assign bus.out_valid_o = w_out_valid;
    assign bus.out_data_o  = r_out_data;
    assign idle_o          = (r_state == S_EMPTY) && bus.fifo_empty_i;
    assign count_o         = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_out_data  <= '0;
            r_skid_data <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_data  <= w_out_data_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_count     <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_out_data_nxt  = r_out_data;
        w_skid_data_nxt = r_skid_data;
        // A word accepted in the flush cycle is still delivered, so it is counted.
        w_count_nxt     = r_count + {{(CNT_W-1){1'b0}}, w_acc};

        if (flush_i) begin
            w_state_nxt     = S_EMPTY;
            w_skid_data_nxt = '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_pop) begin
                        w_out_data_nxt = bus.fifo_data_i;
                        w_state_nxt    = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_pop && w_acc) begin
                        w_out_data_nxt = bus.fifo_data_i;
                    end else if (w_pop) begin
                        w_skid_data_nxt = bus.fifo_data_i;
                        w_state_nxt     = S_TWO;
                    end else if (w_acc) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_acc) begin
                        w_out_data_nxt  = r_skid_data;
                        w_skid_data_nxt = '0;
                        w_state_nxt     = S_ONE;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: behavioural FIFO source, random sink, in-order scoreboard.
module tb_fifo_stream_reader;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             idle;
    logic [CNT_W-1:0] count;

    fifo_stream_reader_if #(.DATA_W(DATA_W)) bus ();

    fifo_stream_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .flush_i (flush),
        .idle_o  (idle),
        .count_o (count)
    );

    logic [DATA_W-1:0] mem [0:4095];
    logic [31:0]       rd_ptr = 0;
    logic [31:0]       wr_ptr = 0;
    logic [DATA_W-1:0] exp_q [$];
    int                occ = 0;
    int                cnt = 0;
    int                pop_cnt = 0;
    int                checks = 0;
    int                failures = 0;

    assign bus.fifo_empty_i = (rd_ptr == wr_ptr);
    assign bus.fifo_data_i  = mem[rd_ptr[11:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference FIFO pointer and occupancy model, advanced on the same edge as the DUT.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            occ = 0;
            cnt = 0;
        end else begin
            if (bus.pop_o) begin
                rd_ptr <= rd_ptr + 1;
                pop_cnt++;
            end
            if (bus.out_valid_o && bus.out_ready_i) cnt++;
            if (flush) occ = 0;
            else occ = occ + int'(bus.pop_o) - int'(bus.out_valid_o && bus.out_ready_i);
        end
    end

    always @(negedge clk) begin
        logic exp_pop;
        logic [DATA_W-1:0] e;
        if (!reset) begin
            exp_pop = (rd_ptr != wr_ptr) && (occ < 2) && !flush;
            checks++;
            if (bus.pop_o !== exp_pop) begin
                failures++;
                $display("FAIL pop_rule: pop_o=%b required=%b occ=%0d t=%0t", bus.pop_o, exp_pop, occ, $time);
            end
            checks++;
            if (bus.out_valid_o !== (occ != 0)) begin
                failures++;
                $display("FAIL valid_rule: out_valid_o=%b required=%b t=%0t", bus.out_valid_o, (occ != 0), $time);
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard: got %h but no word expected t=%0t", bus.out_data_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.out_data_o !== e) begin
                        failures++;
                        $display("FAIL scoreboard: out_data_o=%h required=%h t=%0t", bus.out_data_o, e, $time);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        mem[wr_ptr[11:0]] = d;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(d);
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            tick();
            if (idle && exp_q.size() == 0 && !bus.out_valid_o) done = 1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_drain: timed out with %0d words outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        bus.out_ready_i = 1'b0;
        #2;
        push_word(8'hEE);
        repeat (2) tick();
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== '0 || count !== '0) begin
            failures++;
            $display("FAIL reset_values: valid=%b data=%h count=%0d required 0/00/0", bus.out_valid_o, bus.out_data_o, count);
        end
        checks++;
        if (bus.pop_o !== 1'b0 || idle !== 1'b0) begin
            failures++;
            $display("FAIL reset_pop: pop_o=%b idle=%b required pop 0 idle 0", bus.pop_o, idle);
        end
        reset = 1'b0;
        bus.out_ready_i = 1'b1;
        wait_drain("reset");
    endtask

    task automatic test_stream();
        int c0 = cnt;
        bus.out_ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(DATA_W'(i));
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== DATA_W'(i)) begin
                failures++;
                $display("FAIL stream_seq: valid=%b data=%h required 1/%h", bus.out_valid_o, bus.out_data_o, DATA_W'(i));
            end
        end
        tick();
        checks++;
        if (bus.out_valid_o !== 1'b0 || idle !== 1'b1 || count !== CNT_W'(c0 + 8)) begin
            failures++;
            $display("FAIL stream_end: valid=%b idle=%b count=%0d required 0/1/%0d", bus.out_valid_o, idle, count, CNT_W'(c0 + 8));
        end
    endtask

    task automatic test_backpressure();
        int p0 = pop_cnt;
        int c0 = cnt;
        bus.out_ready_i = 1'b0;
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 8'hA1 || bus.pop_o !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold: valid=%b data=%h pop=%b required 1/a1/0", bus.out_valid_o, bus.out_data_o, bus.pop_o);
            end
        end
        checks++;
        if (pop_cnt - p0 != 2) begin
            failures++;
            $display("FAIL bp_pops: pops=%0d required 2", pop_cnt - p0);
        end
        bus.out_ready_i = 1'b1;
        wait_drain("bp");
        checks++;
        if (count !== CNT_W'(c0 + 3)) begin
            failures++;
            $display("FAIL bp_count: count=%0d required %0d", count, CNT_W'(c0 + 3));
        end
    endtask

    task automatic test_random();
        int c0 = cnt;
        int pushed = 0;
        bit done = 0;
        for (int c = 0; c < 20000 && !done; c++) begin
            tick();
            bus.out_ready_i = 1'($urandom_range(0, 1));
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                push_word(DATA_W'($urandom));
                pushed++;
            end
            if (pushed == 1000 && exp_q.size() == 0) done = 1;
        end
        bus.out_ready_i = 1'b1;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL random_drain: %0d words outstanding, required 0", exp_q.size());
        end
        tick();
        checks++;
        if (count !== CNT_W'(c0 + 1000)) begin
            failures++;
            $display("FAIL random_count: count=%0d required %0d", count, CNT_W'(c0 + 1000));
        end
    endtask

    task automatic test_flush();
        int c0;
        bus.out_ready_i = 1'b0;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        repeat (3) tick();
        c0 = cnt;
        flush = 1'b1;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        #1;
        checks++;
        if (bus.pop_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_pop: pop_o=%b required 0", bus.pop_o);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (bus.out_valid_o !== 1'b0 || count !== CNT_W'(c0)) begin
            failures++;
            $display("FAIL flush_clear: valid=%b count=%0d required 0/%0d", bus.out_valid_o, count, CNT_W'(c0));
        end
        tick();
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 8'h33) begin
            failures++;
            $display("FAIL flush_next: valid=%b data=%h required 1/33", bus.out_valid_o, bus.out_data_o);
        end
        bus.out_ready_i = 1'b1;
        wait_drain("flush");
    endtask

    task automatic test_async_reset();
        bus.out_ready_i = 1'b0;
        push_word(8'h5A);
        repeat (2) tick();
        checks++;
        if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 8'h5A) begin
            failures++;
            $display("FAIL arst_pre: valid=%b data=%h required 1/5a", bus.out_valid_o, bus.out_data_o);
        end
        #2;
        reset = 1'b1;
        void'(exp_q.pop_front());
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== '0 || count !== '0) begin
            failures++;
            $display("FAIL arst_now: valid=%b data=%h count=%0d required 0/00/0", bus.out_valid_o, bus.out_data_o, count);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_count_wrap();
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 17; i++) push_word(DATA_W'(8'h60 + i));
        wait_drain("wrap");
        checks++;
        if (count !== 4'd1) begin
            failures++;
            $display("FAIL count_wrap: count=%0d required 1", count);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_flush();
        test_async_reset();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
